multicycle_control: RTL

- Multi-cycle successor to the single-cycle RV32I control decoder. Holds per-instruction state in an FSM.
- Sequences fetch, decode, execute, memory and writeback over several cycles. Waits on a shared instruction/data memory through a ready handshake.
- Extends decoding to I-type ALU, BEQ/BNE and JAL. Flags illegal opcodes and counts retired instructions.
- Sits between the instruction register and the shared-memory datapath; drives every datapath mux and enable.

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: instruction fields and status in, every mux/enable out.
interface multicycle_control_if #(
    parameter int RETIRE_W = 32
);
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                alu_zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_write;
    logic                adr_src;
    logic                ir_write;
    logic                pc_write;
    logic                reg_write;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          result_src;
    logic [2:0]          imm_src;
    logic [3:0]          alu_control;
    logic                illegal;
    logic                retire;
    logic [RETIRE_W-1:0] retired_count;

    modport master (
        input  opcode, funct3, funct7, alu_zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               illegal, retire, retired_count
    );

    modport slave (
        output opcode, funct3, funct7, alu_zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               illegal, retire, retired_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM over a shared instruction/data memory with a ready handshake.
package multicycle_control_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
endpackage

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit ENABLE_BRANCH = 1'b1,
    parameter bit ENABLE_JUMP   = 1'b1,
    parameter int RETIRE_W      = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [3:0] alu_control;
        logic       retire;
    } ctl_t;

    state_t              state_q, state_d;
    logic                illegal_q, illegal_d;
    logic [RETIRE_W-1:0] count_q, count_d;
    ctl_t                ctl, ctl_o;
    logic [3:0]          alu_op;
    logic                alu_bad;
    logic                is_store;

    assign is_store = (bus.opcode == 7'b0100011);

    // Shift encodings only accept funct7 0x00/0x20; anything else is trapped.
    always_comb begin
        alu_op  = ALU_ADD;
        alu_bad = 1'b0;
        case (bus.funct3)
            3'b000: if (state_q == EXECR && bus.funct7[5]) alu_op = ALU_SUB;
            3'b001: begin
                alu_op  = ALU_SLL;
                alu_bad = !(bus.funct7 == 7'h00 || bus.funct7 == 7'h20);
            end
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: begin
                alu_op  = (bus.funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                alu_bad = !(bus.funct7 == 7'h00 || bus.funct7 == 7'h20);
            end
            3'b110: alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ctl     = '0;
        case (state_q)
            FETCH: begin
                ctl.mem_req     = 1'b1;
                ctl.alu_src_b   = 2'b10;
                ctl.alu_control = ALU_ADD;
                ctl.result_src  = 2'b10;
                if (bus.mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                ctl.alu_src_a   = 2'b01;
                ctl.alu_src_b   = 2'b01;
                ctl.imm_src     = 3'b010;
                ctl.alu_control = ALU_ADD;
                case (bus.opcode)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = ENABLE_BRANCH ? BRANCH : TRAP;
                    7'b1101111:             state_d = ENABLE_JUMP ? JAL : TRAP;
                    default:                state_d = TRAP;
                endcase
            end
            MEMADR: begin
                ctl.alu_src_a   = 2'b10;
                ctl.alu_src_b   = 2'b01;
                ctl.alu_control = ALU_ADD;
                ctl.imm_src     = is_store ? 3'b001 : 3'b000;
                state_d         = is_store ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                ctl.mem_req = 1'b1;
                ctl.adr_src = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ctl.result_src = 2'b01;
                ctl.reg_write  = 1'b1;
                ctl.retire     = 1'b1;
                state_d        = FETCH;
            end
            MEMWRITE: begin
                ctl.mem_req   = 1'b1;
                ctl.mem_write = 1'b1;
                ctl.adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    ctl.retire = 1'b1;
                    state_d    = FETCH;
                end
            end
            EXECR, EXECI: begin
                ctl.alu_src_a   = 2'b10;
                ctl.alu_src_b   = (state_q == EXECI) ? 2'b01 : 2'b00;
                ctl.alu_control = alu_op;
                state_d         = alu_bad ? TRAP : ALUWB;
            end
            ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.retire    = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                ctl.alu_src_a   = 2'b10;
                ctl.alu_control = ALU_SUB;
                case (bus.funct3)
                    3'b000: begin
                        ctl.pc_write = bus.alu_zero;
                        ctl.retire   = 1'b1;
                        state_d      = FETCH;
                    end
                    3'b001: begin
                        ctl.pc_write = !bus.alu_zero;
                        ctl.retire   = 1'b1;
                        state_d      = FETCH;
                    end
                    default: state_d = TRAP;
                endcase
            end
            JAL: begin
                ctl.alu_src_a   = 2'b01;
                ctl.alu_src_b   = 2'b10;
                ctl.alu_control = ALU_ADD;
                ctl.imm_src     = 3'b011;
                ctl.pc_write    = 1'b1;
                state_d         = ALUWB;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    assign illegal_d = illegal_q | (state_d == TRAP);
    assign count_d   = count_q + RETIRE_W'(ctl.retire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // FETCH decodes as mem_req=1 even in reset, so gate everything with rst_n.
    assign ctl_o = rst_n ? ctl : '0;

    assign bus.mem_req       = ctl_o.mem_req;
    assign bus.mem_write     = ctl_o.mem_write;
    assign bus.adr_src       = ctl_o.adr_src;
    assign bus.ir_write      = ctl_o.ir_write;
    assign bus.pc_write      = ctl_o.pc_write;
    assign bus.reg_write     = ctl_o.reg_write;
    assign bus.alu_src_a     = ctl_o.alu_src_a;
    assign bus.alu_src_b     = ctl_o.alu_src_b;
    assign bus.result_src    = ctl_o.result_src;
    assign bus.imm_src       = ctl_o.imm_src;
    assign bus.alu_control   = ctl_o.alu_control;
    assign bus.retire        = ctl_o.retire;
    assign bus.illegal       = illegal_q;
    assign bus.retired_count = count_q;
endmodule
